ref_loader: RTL and testbench

REF_LOADER -- requirements
Module: ref_loader

---
 rtl/ref_loader.sv | 122 ++++++++++++
 tb/tb_ref_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ref_loader.sv
// Reference-memory row loader: streams rows into X banks, one row per accepted beat.
// Optional build macro REF_LOADER_PIXEL_REVERSE_EN reverses pixel order within each row.
module ref_loader #(
  parameter int PIXEL  = 8,
  parameter int X      = 32,
  parameter int ADDR_W = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [11:0]           row_count,
  input  logic [X*PIXEL-1:0]    pix_in,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic [X*PIXEL-1:0]    ref_input,
  output logic [X-1:0]          Bank_sel,
  output logic [X*ADDR_W-1:0]   write_address_all,
  output logic                  busy,
  output logic                  done
);

  localparam int BW = $clog2(X);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   base_q;
  logic [11:0]         rows_q;
  logic [11:0]         row_idx;

  logic                vld_p0;
  logic                last_p0;
  logic [BW-1:0]       bank_p0;
  logic [ADDR_W-1:0]   addr_p0;
  logic [X-1:0]        sel_p0;
  logic [X*ADDR_W-1:0] wa_p0;

  function automatic logic [X*PIXEL-1:0] pixel_order(input logic [X*PIXEL-1:0] d);
`ifdef REF_LOADER_PIXEL_REVERSE_EN
    logic [X*PIXEL-1:0] r;
    for (int k = 0; k < X; k++) r[k*PIXEL +: PIXEL] = d[(X-1-k)*PIXEL +: PIXEL];
    return r;
`else
    return d;
`endif
  endfunction

  // stage p0: beat acceptance and bank/address decode of the current row index
  assign vld_p0  = pix_valid && (state == LOAD);
  assign last_p0 = (row_idx == rows_q - 12'd1);
  assign bank_p0 = row_idx[BW-1:0];
  assign addr_p0 = base_q + ADDR_W'(row_idx >> BW);

  always_comb begin
    sel_p0 = '0;
    wa_p0  = '0;
    for (int b = 0; b < X; b++) begin
      if (bank_p0 == BW'(b)) begin
        sel_p0[b]                   = 1'b1;
        wa_p0[b*ADDR_W +: ADDR_W]   = addr_p0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pix_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (row_count == '0) ? DONE : LOAD;
      end
      LOAD: begin
        pix_ready = 1'b1;
        if (vld_p0 && last_p0) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      base_q  <= '0;
      rows_q  <= '0;
      row_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        base_q  <= base_addr;
        rows_q  <= row_count;
        row_idx <= '0;
      end else if (vld_p0) begin
        row_idx <= row_idx + 12'd1;
      end
    end
  end

  // stage p1: registered bank write; enables and addresses clear on idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_input         <= '0;
      Bank_sel          <= '0;
      write_address_all <= '0;
    end else if (vld_p0) begin
      ref_input         <= pixel_order(pix_in);
      Bank_sel          <= sel_p0;
      write_address_all <= wa_p0;
    end else begin
      Bank_sel          <= '0;
      write_address_all <= '0;
    end
  end

endmodule

// File: tb/tb_ref_loader.sv
// Scoreboard bench for ref_loader: the driver queues expected bank writes, a negedge monitor checks them.
module tb_ref_loader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [6:0]   base_addr = '0;
  logic [11:0]  row_count = '0;
  logic [255:0] pix_in = '0;
  logic         pix_valid = 1'b0;
  logic         pix_ready;
  logic [255:0] ref_input;
  logic [31:0]  Bank_sel;
  logic [223:0] write_address_all;
  logic         busy;
  logic         done;

  ref_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .row_count(row_count), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .ref_input(ref_input), .Bank_sel(Bank_sel),
    .write_address_all(write_address_all), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  sel;
    logic [223:0] wa;
    logic [255:0] data;
    logic         dn;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [255:0] last_data = '0;
  int           checks = 0;
  int           failures = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [255:0] row_data(input int r);
    logic [7:0] b;
    b = 8'(r + 1);
    return {32{b}};
  endfunction

  // Expected write: bank r mod 32, address (base + r/32) mod 128 in that bank's slot.
  task automatic push_write(input int r, input logic [6:0] base, input logic [255:0] data,
                            input logic dn);
    exp_t e;
    int   bank;
    bank    = r % 32;
    e.sel   = 32'd1 << bank;
    e.wa    = '0;
    e.wa[bank*7 +: 7] = 7'((int'(base) + r / 32) % 128);
    e.data  = data;
    e.dn    = dn;
    last_data = data;
    sb.push_back(e);
  endtask

  task automatic push_done_only();
    exp_t e;
    e.sel  = '0;
    e.wa   = '0;
    e.data = last_data;
    e.dn   = 1'b1;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (Bank_sel != '0 || done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual sel=%h done=%b required none", Bank_sel, done);
      end else begin
        mon_e = sb.pop_front();
        chk("bank_sel", 256'(Bank_sel), 256'(mon_e.sel));
        chk("write_addr", 256'(write_address_all), 256'(mon_e.wa));
        chk("ref_input", ref_input, mon_e.data);
        chk("done", 256'(done), 256'(mon_e.dn));
      end
    end
  end

  // Tasks below start and end at 1 time unit after a rising edge.
  task automatic start_load(input logic [6:0] base, input logic [11:0] cnt);
    start     = 1'b1;
    base_addr = base;
    row_count = cnt;
    if (cnt == 12'd0) push_done_only();
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 256'(busy), 256'd1);
  endtask

  task automatic beat(input int r, input logic [6:0] base, input logic [11:0] cnt,
                      input logic [255:0] data);
    chk("pix_ready", 256'(pix_ready), 256'd1);
    pix_valid = 1'b1;
    pix_in    = data;
    push_write(r, base, data, r == int'(cnt) - 1);
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic run_load(input logic [6:0] base, input logic [11:0] cnt);
    start_load(base, cnt);
    for (int r = 0; r < int'(cnt); r++) beat(r, base, cnt, row_data(r));
    @(posedge clk); #1;
    chk("idle_after_load", 256'(busy), 256'd0);
    chk("sb_empty", 256'(sb.size()), 256'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ref_input"}, ref_input, 256'd0);
    chk({tag, "_bank_sel"}, 256'(Bank_sel), 256'd0);
    chk({tag, "_waddr"}, 256'(write_address_all), 256'd0);
    chk({tag, "_pix_ready"}, 256'(pix_ready), 256'd0);
    chk({tag, "_busy"}, 256'(busy), 256'd0);
    chk({tag, "_done"}, 256'(done), 256'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] vin, vexp;
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // four rows from base 0: banks 0..3, address 0
    run_load(7'd0, 12'd4);
    // 33 rows from base 5: row 32 goes to bank 0 at address 6
    run_load(7'd5, 12'd33);
    // 64 rows from base 127: second half wraps to address 0
    run_load(7'd127, 12'd64);

    // empty load: done only, no write, never ready
    start_load(7'd3, 12'd0);
    chk("zero_pix_ready", 256'(pix_ready), 256'd0);
    chk("zero_done", 256'(done), 256'd1);
    @(posedge clk); #1;
    chk("zero_idle", 256'(busy), 256'd0);
    chk("zero_sb_empty", 256'(sb.size()), 256'd0);

    // valid gaps, plus a start that must be ignored mid-load
    start_load(7'd9, 12'd2);
    beat(0, 7'd9, 12'd2, row_data(0));
    start     = 1'b1;
    base_addr = 7'd50;
    row_count = 12'd9;
    @(posedge clk); #1;
    start = 1'b0;
    chk("gap1_bank_sel", 256'(Bank_sel), 256'd0);
    chk("gap1_busy", 256'(busy), 256'd1);
    @(posedge clk); #1;
    chk("gap2_bank_sel", 256'(Bank_sel), 256'd0);
    beat(1, 7'd9, 12'd2, row_data(1));
    @(posedge clk); #1;
    chk("gap_idle", 256'(busy), 256'd0);
    @(posedge clk); #1;
    chk("gap_still_idle", 256'(busy), 256'd0);
    chk("gap_sb_empty", 256'(sb.size()), 256'd0);

    // reset after three of eight rows
    start_load(7'd20, 12'd8);
    for (int r = 0; r < 3; r++) beat(r, 7'd20, 12'd8, row_data(r));
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    last_data = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    pix_valid = 1'b1;
    pix_in    = row_data(7);
    @(posedge clk); #1;
    chk("post_reset_bank_sel", 256'(Bank_sel), 256'd0);
    chk("post_reset_busy", 256'(busy), 256'd0);
    pix_valid = 1'b0;
    chk("reset_sb_empty", 256'(sb.size()), 256'd0);

    // pixel-order vector: pixel k of the input holds value k
    for (int k = 0; k < 32; k++) begin
      vin[k*8 +: 8] = 8'(k);
`ifdef REF_LOADER_PIXEL_REVERSE_EN
      vexp[k*8 +: 8] = 8'(31 - k);
`else
      vexp[k*8 +: 8] = 8'(k);
`endif
    end
    start_load(7'd0, 12'd1);
    chk("pix_ready_order", 256'(pix_ready), 256'd1);
    pix_valid = 1'b1;
    pix_in    = vin;
    push_write(0, 7'd0, vexp, 1'b1);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    chk("final_sb_empty", 256'(sb.size()), 256'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
